// File: rtl/mod_147_10_hb_engine.sv
// mod_147_10_hb_engine: Clause 147 heartbeat engine with miss supervision and collision retry limit
module mod_147_10_hb_engine #(
  parameter int TMR_W = 24,
  parameter logic [TMR_W-1:0] HB_PERIOD = 24'd2500000,
  parameter logic [TMR_W-1:0] HB_SEND_CYCLES = 24'd64,
  parameter int MISS_LIMIT = 3,
  parameter int COL_LIMIT = 4
) (
  input  logic       clk,
  input  logic       pcs_reset_n,
  input  logic       mr_autoneg_enable,
  input  logic       an_link_good,
  input  logic       multidrop,
  input  logic       master,
  input  logic [1:0] rx_cmd,
  input  logic [1:0] tx_cmd,
  input  logic       CRS,
  input  logic       COL,
  input  logic       RX_DV,
  output logic [3:0] state,
  output logic [1:0] hb_cmd,
  output logic       hb_lost,
  output logic       hb_col_fault
);
  typedef enum logic [3:0] {
    INIT = 4'd0, WAIT_TMR = 4'd1, DISABLE_HB = 4'd2, TX_HB = 4'd3, COLLIDE = 4'd4,
    COOLDOWN = 4'd5, WAIT_HB = 4'd6, WAIT_TX = 4'd7, WAIT_RX = 4'd8, REPLY_HB = 4'd9
  } st_t;
  st_t st, nxt;
  logic [TMR_W-1:0] hb_tmr, send_tmr, miss_tmr;
  logic [3:0] col_cnt, miss_cnt, miss_inc;
  logic run, beacon, enter, hb_done, send_done, miss_done, col_max, send_ld;
  assign state = st;
  always_comb begin
    run = mr_autoneg_enable & an_link_good & ~multidrop;
    beacon = (rx_cmd == 2'b00) | (tx_cmd == 2'b00);
    hb_done = hb_tmr == '0;
    send_done = send_tmr == '0;
    miss_done = miss_tmr == '0;
    col_max = col_cnt == 4'(COL_LIMIT - 1);
    miss_inc = (miss_cnt == 4'd15) ? miss_cnt : miss_cnt + 4'd1;
    nxt = st;
    case (st)
      INIT:       nxt = master ? WAIT_TMR : WAIT_HB;
      WAIT_TMR:   nxt = (hb_done & ~CRS) ? TX_HB : WAIT_TMR;
      TX_HB:      nxt = COL ? (col_max ? WAIT_TMR : COLLIDE) : (send_done ? WAIT_TMR : TX_HB);
      COLLIDE:    nxt = CRS ? COLLIDE : COOLDOWN;
      COOLDOWN:   nxt = send_done ? TX_HB : COOLDOWN;
      DISABLE_HB: nxt = DISABLE_HB;
      WAIT_HB:    nxt = ((rx_cmd == 2'b10) | RX_DV) ? WAIT_RX : WAIT_HB;
      WAIT_RX:    nxt = CRS ? WAIT_RX : WAIT_TX;
      WAIT_TX:    nxt = send_done ? REPLY_HB : WAIT_TX;
      REPLY_HB:   nxt = send_done ? WAIT_HB : REPLY_HB;
      default:    nxt = INIT;
    endcase
    if (!run) nxt = INIT;
    else if (beacon) nxt = DISABLE_HB;
    // every entry (including re-entry from another state) reloads the owning timer
    enter = nxt != st;
    send_ld = enter & ((nxt == TX_HB) | (nxt == COOLDOWN) | (nxt == WAIT_TX) | (nxt == REPLY_HB));
  end
  always_ff @(posedge clk) begin
    if (!pcs_reset_n) begin
      st <= INIT;
      hb_tmr <= '0;
      send_tmr <= '0;
      miss_tmr <= '0;
      col_cnt <= '0;
      miss_cnt <= '0;
      hb_lost <= 1'b0;
      hb_col_fault <= 1'b0;
      hb_cmd <= 2'b11;
    end else begin
      st <= nxt;
      hb_cmd <= ((nxt == TX_HB) | (nxt == REPLY_HB)) ? 2'b10 : 2'b11;
      hb_tmr <= (enter & (nxt == WAIT_TMR)) ? HB_PERIOD - TMR_W'(1) : hb_done ? hb_tmr : hb_tmr - TMR_W'(1);
      send_tmr <= send_ld ? HB_SEND_CYCLES - TMR_W'(1) : send_done ? send_tmr : send_tmr - TMR_W'(1);
      miss_tmr <= ((enter & (nxt == WAIT_HB)) | ((st == WAIT_HB) & miss_done)) ? HB_PERIOD - TMR_W'(1) :
                  miss_done ? miss_tmr : miss_tmr - TMR_W'(1);
      hb_col_fault <= run & ~beacon & (st == TX_HB) & COL & col_max;
      if (!run) col_cnt <= '0;
      else if ((st == TX_HB) & (nxt == COLLIDE)) col_cnt <= col_cnt + 4'd1;
      else if ((st == TX_HB) & (nxt == WAIT_TMR)) col_cnt <= '0;
      if (!run | ((st == WAIT_HB) & (nxt == WAIT_RX))) begin
        miss_cnt <= '0;
        hb_lost <= 1'b0;
      end else if ((st == WAIT_HB) & (nxt == WAIT_HB) & miss_done) begin
        miss_cnt <= miss_inc;
        hb_lost <= hb_lost | (miss_inc >= 4'(MISS_LIMIT));
      end
    end
  end
endmodule

// File: doc/mod_147_10_hb_engine.md
# mod_147_10_hb_engine

Parametrised, synthesisable heartbeat engine for the Clause 147 point-to-point PHY; the next generation of the heartbeat state diagram. It integrates the hb_timer and hb_send_timer as internal down-counters with parametrised periods. It adds two behaviours: follower-side missed-heartbeat supervision (hb_lost) and a master-side collision retry limit (hb_col_fault). It sits between the PCS command path (rx_cmd/tx_cmd) and the transmit command mux that consumes hb_cmd.

## Interface
- TMR_W, 24: width of both internal timers; periods below must fit.
- HB_PERIOD, 24'd2500000: hb_timer length in clk cycles.
- HB_SEND_CYCLES, 24'd64: hb_send_timer length in clk cycles.
- MISS_LIMIT, 3: consecutive missed heartbeat periods before hb_lost; range 1..15.
- COL_LIMIT, 4: consecutive collided heartbeat attempts before abandon; range 1..15.
- clk  in  1  PCS clock; all logic on rising edge.
- pcs_reset_n  in  1  synchronous, active-low reset.
- mr_autoneg_enable, an_link_good, multidrop, master  in  1 each  link/config qualifiers.
- rx_cmd, tx_cmd  in  2 each  command codes: BEACON=00, COMMIT=01, HEARTBEAT=10, NONE=11.
- CRS, COL, RX_DV  in  1 each  MII status.
- state  out  4  current state, encoded below.
- hb_cmd  out  2  NONE (11) or HEARTBEAT (10).
- hb_lost  out  1  sticky follower loss flag.
- hb_col_fault  out  1  one-cycle pulse on abandoned heartbeat.

## Operation
- States: INIT 0, WAIT_TMR 1, DISABLE_HB 2, TX_HB 3, COLLIDE 4, COOLDOWN 5, WAIT_HB 6, WAIT_TX 7, WAIT_RX 8, REPLY_HB 9. Codes 10-15 illegal; they go to INIT next cycle.
- Priority, evaluated each cycle:
  - !pcs_reset_n: all registers reset.
  - else run = mr_autoneg_enable & an_link_good & !multidrop. If !run: go to INIT, clear miss/col counters and hb_lost.
  - else if rx_cmd==BEACON or tx_cmd==BEACON: go to DISABLE_HB.
  - else per-state transitions below.
- Transitions:
  - INIT: master → WAIT_TMR; else → WAIT_HB.
  - WAIT_TMR: hb_timer_done & !CRS → TX_HB.
  - TX_HB: COL → COLLIDE, or → WAIT_TMR if col_cnt==COL_LIMIT-1. Else hb_send_timer_done → WAIT_TMR, clearing col_cnt.
  - COLLIDE: !CRS → COOLDOWN.
  - COOLDOWN: hb_send_timer_done → TX_HB.
  - DISABLE_HB: no exit; left only via the INIT condition.
  - WAIT_HB: rx_cmd==HEARTBEAT or RX_DV → WAIT_RX.
  - WAIT_RX: !CRS → WAIT_TX.
  - WAIT_TX: hb_send_timer_done → REPLY_HB.
  - REPLY_HB: hb_send_timer_done → WAIT_HB.
- Timers:
  - Loaded with period-1 on the edge entering the starting state; decrement to 0 and hold there; done = (count==0).
  - hb_timer starts on entry to WAIT_TMR.
  - hb_send_timer starts on entry to TX_HB, COOLDOWN, WAIT_TX and REPLY_HB.
  - Re-entry reloads the timer.
- Collision counting (4-bit col_cnt):
  - col_cnt increments on each TX_HB→COLLIDE.
  - At the limit: hb_col_fault pulses for the cycle following the edge, col_cnt clears, and the engine returns to WAIT_TMR.
- Miss supervision (follower):
  - A separate miss timer (TMR_W bits) is loaded with HB_PERIOD-1 on entry to WAIT_HB.
  - While in WAIT_HB, expiry increments miss_cnt (saturating at 15) and reloads the timer.
  - hb_lost is set when miss_cnt reaches MISS_LIMIT.
  - The WAIT_HB→WAIT_RX transition clears miss_cnt and hb_lost.
- hb_cmd = HEARTBEAT iff the registered state is TX_HB or REPLY_HB; NONE otherwise.

## Timing
- Reset values: state=INIT, hb_cmd=NONE, hb_lost=0, hb_col_fault=0; all counters 0.
- State and all outputs are registered. One transition per clock, so INIT takes exactly one cycle.
- Dwell times:
  - WAIT_TMR with CRS low: exactly HB_PERIOD cycles.
  - TX_HB with no COL: exactly HB_SEND_CYCLES cycles.
  - CRS high at timer expiry holds WAIT_TMR; TX_HB follows the first cycle CRS is low.
- Simultaneous events:
  - COL and hb_send_timer_done in the same cycle: COL wins.
  - BEACON in any state beats all per-state transitions.
  - Loss of run beats BEACON.
- Reset or loss of run mid-heartbeat: hb_cmd returns to NONE on the next edge.

## Test plan
Overrides for all scenarios: HB_PERIOD=16, HB_SEND_CYCLES=4, MISS_LIMIT=3, COL_LIMIT=3.
- Master, quiet line, release reset → INIT 1 cycle, WAIT_TMR 16 cycles, then hb_cmd=HEARTBEAT for exactly 4 cycles, repeating every 20 cycles.
- Master, COL asserted 1 cycle into each TX_HB with CRS high 2 cycles → COLLIDE→COOLDOWN(4)→TX_HB twice. On the third COL: hb_col_fault pulses once, state=WAIT_TMR, col_cnt=0.
- Follower, rx_cmd=HEARTBEAT for 1 cycle, CRS low → WAIT_RX, WAIT_TX(4), REPLY_HB with HEARTBEAT for 4 cycles, then WAIT_HB.
- Follower, no heartbeat → hb_lost rises at 48 cycles after entering WAIT_HB; a later RX_DV clears it on the next edge.
- rx_cmd=BEACON during TX_HB → DISABLE_HB, hb_cmd=NONE, stays after BEACON drops; an_link_good=0 → INIT.
- Deassert pcs_reset_n mid-REPLY_HB → next edge: state=INIT, all outputs at reset values.
